score_keeper: RTL and testbench
===============================

# score_keeper

Game-score engine between the player controller and the score renderer. Counts the running score in packed BCD, paced by the 60 Hz game tick, while the game runs. Keeps a session high score and flags a new record at game over. Serves single digits to the renderer and a milestone pulse to the audio block.

## Interface

Parameters:
- TICKS_PER_POINT, default 6: game ticks per score point (6 gives 10 points/s at 60 Hz); legal range 1–255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- game_start  input  1  one-cycle pulse from player controller
- game_over  input  1  one-cycle pulse from player controller
- game_tick  input  1  one-cycle 60 Hz pulse from graphics timing
- i_digit_sel  input  3  digit select: 0–3 score digits (0 = ones), 4–7 high-score digits (4 = ones)
- o_digit  output  4  registered BCD digit selected by i_digit_sel
- o_score_bcd  output  16  current score, 4 packed BCD digits, thousands in [15:12]
- o_hiscore_bcd  output  16  session high score, same packing
- o_new_hiscore  output  1  level; last finished game set a record
- o_milestone  output  1  one-cycle pulse when the score crosses a multiple of 100
- o_running  output  1  level; state is RUNNING

## Operation

- Reset values: state IDLE, prescaler 0, and all outputs 0.
- States:
  - IDLE → RUNNING on game_start.
  - RUNNING → OVER on game_over.
  - OVER → RUNNING on game_start.
  - No other transitions.
- Start handling:
  - game_start in IDLE or OVER clears the score, the prescaler and o_new_hiscore.
  - game_start in RUNNING is ignored.
- Prescaler:
  - Counts game_tick only in RUNNING.
  - A tick with prescaler = TICKS_PER_POINT−1 wraps it to 0 and increments the score.
  - Width is 8 bits.
- Score increment:
  - BCD ripple: each digit wraps 9→0 and carries into the next digit.
  - Saturates at 9999; further scoring ticks leave it at 9999.
  - The prescaler keeps cycling during saturation.
- o_milestone: pulses for exactly the cycle after an increment whose result has ones and tens digits both 0 (e.g. 0099→0100).
  - No pulse while saturated.
  - No pulse on clearing to 0000.
- Game over, sampled in RUNNING:
  - If score > hiscore (unsigned 16-bit compare; valid for packed BCD), the high score takes the score and o_new_hiscore is set.
  - Equal score is not a record.
  - game_over outside RUNNING is ignored.
- Simultaneous events:
  - game_over with a scoring tick in the same cycle: game_over wins. No increment. The compare uses the pre-increment score.
  - game_start with game_over in the same cycle:
    - In RUNNING: game_over applies and game_start is ignored.
    - In IDLE/OVER: game_start applies.
- High score survives game_start. Only rst_n clears it.
- o_digit: the digit selected by i_digit_sel, registered.
- Reset mid-game: all state returns to reset values asynchronously, high score included. No milestone pulse is emitted.

## Timing

- All outputs are registered. No combinational input-to-output path.
- Score, o_milestone and prescaler updates are visible one cycle after the sampling edge of game_tick.
- State, o_running, o_hiscore_bcd and o_new_hiscore are visible one cycle after the sampling edge of game_start/game_over.
- o_digit latency is 1 cycle from i_digit_sel. The renderer presents the select one cycle early.
- o_milestone width is exactly 1 clk cycle. It never occurs on two consecutive cycles.
- game_tick pulses are at least 2 cycles apart. No behaviour depends on tick spacing beyond this.

## Test plan

1. Reset, game_start, 60 ticks (TICKS_PER_POINT=6).
   - o_score_bcd = 16'h0010, o_running = 1, o_milestone never asserted.
2. 600 ticks after start.
   - o_score_bcd = 16'h0100.
   - o_milestone asserted exactly once, the cycle after the 0099→0100 increment.
   - o_digit with i_digit_sel = 2 reads 1 one cycle after select.
3. Run to 59994 ticks, then 12 more.
   - Score reaches 16'h9999 and holds.
   - Milestone pulses total 99, none after 9900.
4. Game 1 ends at 0042: o_hiscore_bcd = 0042, o_new_hiscore = 1.
   - game_start clears o_new_hiscore. Game 2 ends at 0042: no update, flag 0.
   - Game 3 ends at 0043: high score 0043, flag 1.
5. Score 0041, prescaler 5; game_over coincident with game_tick.
   - Final score 0041, high score 0041, state OVER.
   - Later ticks do not change the score.
6. rst_n low mid-run at score 0150 with high score 0300.
   - All outputs 0 immediately (asynchronous).
   - After release, game_start is needed to count, and the high score reads 0000.

Source files
------------

// File: rtl/score_keeper_if.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper_if
// Brief    : Controller / renderer side signals of the score engine.
// Revision : 1.0
// ============================================================================
interface score_keeper_if;
   logic        game_start;
   logic        game_over;
   logic        game_tick;
   logic [2:0]  i_digit_sel;
   logic [3:0]  o_digit;
   logic [15:0] o_score_bcd;
   logic [15:0] o_hiscore_bcd;
   logic        o_new_hiscore;
   logic        o_milestone;
   logic        o_running;

   modport master (
      output game_start, game_over, game_tick, i_digit_sel,
      input  o_digit, o_score_bcd, o_hiscore_bcd, o_new_hiscore, o_milestone, o_running
   );

   modport slave (
      input  game_start, game_over, game_tick, i_digit_sel,
      output o_digit, o_score_bcd, o_hiscore_bcd, o_new_hiscore, o_milestone, o_running
   );
endinterface
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Brief    : Tick-paced BCD score counter with session high score and digit server.
// Revision : 1.0
// ============================================================================
module score_keeper #(
   parameter int TICKS_PER_POINT = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   score_keeper_if.slave  bus
);

   localparam logic [1:0]  ST_IDLE          = 2'd0;
   localparam logic [1:0]  ST_RUNNING       = 2'd1;
   localparam logic [1:0]  ST_OVER          = 2'd2;
   localparam logic [7:0]  C_PRESCALE_LAST  = 8'(TICKS_PER_POINT - 1);
   localparam logic [15:0] C_SCORE_MAX      = 16'h9999;

   logic [1:0]  state_q, state_d;
   logic [7:0]  prescaler_q, prescaler_d;
   logic [15:0] score_q, score_d;
   logic [15:0] hiscore_q, hiscore_d;
   logic        new_hiscore_q, new_hiscore_d;
   logic        milestone_q, milestone_d;
   logic        running_q, running_d;
   logic [3:0]  digit_q, digit_d;

   logic        start_ok;
   logic        over_ok;
   logic        tick_ok;
   logic        point_ok;
   logic [15:0] score_inc;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // game_over takes priority over a coincident tick, so a tick only counts without it
   assign start_ok  = bus.game_start && (state_q != ST_RUNNING);
   assign over_ok   = bus.game_over  && (state_q == ST_RUNNING);
   assign tick_ok   = bus.game_tick  && (state_q == ST_RUNNING) && !bus.game_over;
   assign point_ok  = tick_ok && (prescaler_q == C_PRESCALE_LAST);
   assign score_inc = bcd_inc(score_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (bus.game_start) state_d = ST_RUNNING;
         ST_RUNNING: if (bus.game_over)  state_d = ST_OVER;
         ST_OVER:    if (bus.game_start) state_d = ST_RUNNING;
         default:                        state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      running_d = (state_d == ST_RUNNING);
   end

   always_comb begin
      prescaler_d   = prescaler_q;
      score_d       = score_q;
      hiscore_d     = hiscore_q;
      new_hiscore_d = new_hiscore_q;
      milestone_d   = 1'b0;
      if (start_ok) begin
         prescaler_d   = 8'd0;
         score_d       = 16'h0000;
         new_hiscore_d = 1'b0;
      end else if (over_ok) begin
         // packed BCD orders the same as plain binary
         if (score_q > hiscore_q) begin
            hiscore_d     = score_q;
            new_hiscore_d = 1'b1;
         end
      end else if (tick_ok) begin
         if (point_ok) begin
            prescaler_d = 8'd0;
            if (score_q != C_SCORE_MAX) begin
               score_d     = score_inc;
               milestone_d = (score_inc[7:0] == 8'h00);
            end
         end else begin
            prescaler_d = prescaler_q + 8'd1;
         end
      end
   end

   always_comb begin
      if (bus.i_digit_sel[2]) begin
         digit_d = hiscore_q[{bus.i_digit_sel[1:0], 2'b00} +: 4];
      end else begin
         digit_d = score_q[{bus.i_digit_sel[1:0], 2'b00} +: 4];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler_q   <= 8'd0;
         score_q       <= 16'h0000;
         hiscore_q     <= 16'h0000;
         new_hiscore_q <= 1'b0;
         milestone_q   <= 1'b0;
         running_q     <= 1'b0;
         digit_q       <= 4'd0;
      end else begin
         prescaler_q   <= prescaler_d;
         score_q       <= score_d;
         hiscore_q     <= hiscore_d;
         new_hiscore_q <= new_hiscore_d;
         milestone_q   <= milestone_d;
         running_q     <= running_d;
         digit_q       <= digit_d;
      end
   end

   assign bus.o_digit       = digit_q;
   assign bus.o_score_bcd   = score_q;
   assign bus.o_hiscore_bcd = hiscore_q;
   assign bus.o_new_hiscore = new_hiscore_q;
   assign bus.o_milestone   = milestone_q;
   assign bus.o_running     = running_q;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_keeper
// Brief    : Random and directed stimulus on two score_keeper instances vs. an integer model.
// Revision : 1.0
// ============================================================================
module tb_score_keeper;

   localparam int TPP_A  = 6;
   localparam int TPP_B  = 1;
   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_OVER = 2;

   typedef struct packed {
      int state;
      int pre;
      int score;
      int hi;
      int digit;
      int milecnt;
      bit newhi;
      bit mile;
   } model_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       game_start;
   logic       game_over;
   logic       game_tick;
   logic [2:0] digit_sel;

   always #5 clk = ~clk;

   score_keeper_if bus_a ();
   score_keeper_if bus_b ();

   assign bus_a.game_start  = game_start;
   assign bus_a.game_over   = game_over;
   assign bus_a.game_tick   = game_tick;
   assign bus_a.i_digit_sel = digit_sel;
   assign bus_b.game_start  = game_start;
   assign bus_b.game_over   = game_over;
   assign bus_b.game_tick   = game_tick;
   assign bus_b.i_digit_sel = digit_sel;

   score_keeper #(.TICKS_PER_POINT(TPP_A)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   score_keeper #(.TICKS_PER_POINT(TPP_B)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   int     n_checks = 0;
   int     n_fail   = 0;
   int     seen_mile_a = 0;
   int     seen_mile_b = 0;
   model_t m_a;
   model_t m_b;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 30) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic int exp_digit(input model_t m, input logic [2:0] sel);
      int v;
      v = sel[2] ? m.hi : m.score;
      for (int i = 0; i < int'(sel[1:0]); i++) v = v / 10;
      return v % 10;
   endfunction

   function automatic model_t model_reset();
      model_t m;
      m = '0;
      m.state = S_IDLE;
      return m;
   endfunction

   // Game rules in plain decimal arithmetic; scores are compared after conversion to BCD.
   function automatic model_t model_next(input model_t m, input int tpp, input bit st,
                                         input bit ov, input bit tk, input logic [2:0] sel);
      model_t n;
      n       = m;
      n.digit = exp_digit(m, sel);
      n.mile  = 1'b0;
      if (m.state == S_RUN) begin
         if (ov) begin
            if (m.score > m.hi) begin
               n.hi    = m.score;
               n.newhi = 1'b1;
            end
            n.state = S_OVER;
         end else if (tk) begin
            if (m.pre == tpp - 1) begin
               n.pre = 0;
               if (m.score < 9999) begin
                  n.score = m.score + 1;
                  if (n.score % 100 == 0) begin
                     n.mile    = 1'b1;
                     n.milecnt = m.milecnt + 1;
                  end
               end
            end else begin
               n.pre = m.pre + 1;
            end
         end
      end else if (st) begin
         n.state = S_RUN;
         n.score = 0;
         n.pre   = 0;
         n.newhi = 1'b0;
      end
      return n;
   endfunction

   task automatic check_dut(input string nm, input model_t m, input logic [15:0] sc,
                            input logic [15:0] hi, input logic nh, input logic ms,
                            input logic rn, input logic [3:0] dg);
      check_val({nm, ".score"},   32'(sc), 32'(to_bcd(m.score)));
      check_val({nm, ".hiscore"}, 32'(hi), 32'(to_bcd(m.hi)));
      check_val({nm, ".new_hi"},  32'(nh), 32'(m.newhi));
      check_val({nm, ".mile"},    32'(ms), 32'(m.mile));
      check_val({nm, ".running"}, 32'(rn), 32'(m.state == S_RUN));
      check_val({nm, ".digit"},   32'(dg), 32'(m.digit));
   endtask

   task automatic check_both();
      check_dut("a", m_a, bus_a.o_score_bcd, bus_a.o_hiscore_bcd, bus_a.o_new_hiscore,
                bus_a.o_milestone, bus_a.o_running, bus_a.o_digit);
      check_dut("b", m_b, bus_b.o_score_bcd, bus_b.o_hiscore_bcd, bus_b.o_new_hiscore,
                bus_b.o_milestone, bus_b.o_running, bus_b.o_digit);
   endtask

   task automatic step();
      @(posedge clk);
      m_a = model_next(m_a, TPP_A, game_start, game_over, game_tick, digit_sel);
      m_b = model_next(m_b, TPP_B, game_start, game_over, game_tick, digit_sel);
      #1;
      check_both();
      if (bus_a.o_milestone) seen_mile_a++;
      if (bus_b.o_milestone) seen_mile_b++;
      game_start = 1'b0;
      game_over  = 1'b0;
      game_tick  = 1'b0;
      digit_sel  = 3'($urandom_range(0, 7));
   endtask

   task automatic run_ticks(input int n, input int max_gap);
      repeat (n) begin
         game_tick = 1'b1;
         step();
         repeat (1 + $urandom_range(0, max_gap)) step();
      end
   endtask

   task automatic pulse_start();
      game_start = 1'b1;
      step();
   endtask

   task automatic pulse_over();
      game_over = 1'b1;
      step();
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      m_a = model_reset();
      m_b = model_reset();
      check_both();
      game_start = 1'b0;
      game_over  = 1'b0;
      game_tick  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b1;
      game_start = 1'b0;
      game_over  = 1'b0;
      game_tick  = 1'b0;
      digit_sel  = 3'd0;
      m_a        = model_reset();
      m_b        = model_reset();
      do_reset();
      step();

      // 60 ticks at 6 per point, then on to 600
      pulse_start();
      run_ticks(60, 1);
      check_val("t1.score", 32'(bus_a.o_score_bcd), 32'h0010);
      check_val("t1.running", 32'(bus_a.o_running), 32'd1);
      check_val("t1.miles", 32'(seen_mile_a), 32'd0);
      run_ticks(540, 1);
      check_val("t2.score", 32'(bus_a.o_score_bcd), 32'h0100);
      check_val("t2.miles", 32'(seen_mile_a), 32'd1);
      digit_sel = 3'd2;
      step();
      check_val("t2.digit", 32'(bus_a.o_digit), 32'd1);

      // instance b (one tick per point) runs into saturation
      run_ticks(9420, 0);
      check_val("t3.score_sat", 32'(bus_b.o_score_bcd), 32'h9999);
      check_val("t3.miles", 32'(seen_mile_b), 32'd99);
      check_val("t3.miles_model", 32'(seen_mile_b), 32'(m_b.milecnt));

      // high-score record rules
      do_reset();
      pulse_start();
      run_ticks(42 * TPP_A, 0);
      pulse_over();
      check_val("t4.hi1", 32'(bus_a.o_hiscore_bcd), 32'h0042);
      check_val("t4.flag1", 32'(bus_a.o_new_hiscore), 32'd1);
      pulse_start();
      check_val("t4.flag_clr", 32'(bus_a.o_new_hiscore), 32'd0);
      run_ticks(42 * TPP_A, 0);
      pulse_over();
      check_val("t4.hi2", 32'(bus_a.o_hiscore_bcd), 32'h0042);
      check_val("t4.flag2", 32'(bus_a.o_new_hiscore), 32'd0);
      pulse_start();
      run_ticks(43 * TPP_A, 0);
      pulse_over();
      check_val("t4.hi3", 32'(bus_a.o_hiscore_bcd), 32'h0043);
      check_val("t4.flag3", 32'(bus_a.o_new_hiscore), 32'd1);

      // game_over coincident with a scoring tick
      do_reset();
      pulse_start();
      run_ticks(41 * TPP_A + 5, 0);
      game_over = 1'b1;
      game_tick = 1'b1;
      step();
      check_val("t5.score", 32'(bus_a.o_score_bcd), 32'h0041);
      check_val("t5.hi", 32'(bus_a.o_hiscore_bcd), 32'h0041);
      check_val("t5.running", 32'(bus_a.o_running), 32'd0);
      run_ticks(12, 0);
      check_val("t5.score_hold", 32'(bus_a.o_score_bcd), 32'h0041);

      // asynchronous reset mid-game
      do_reset();
      pulse_start();
      run_ticks(300 * TPP_A, 0);
      pulse_over();
      pulse_start();
      run_ticks(150 * TPP_A, 0);
      check_val("t6.score", 32'(bus_a.o_score_bcd), 32'h0150);
      check_val("t6.hi", 32'(bus_a.o_hiscore_bcd), 32'h0300);
      do_reset();
      run_ticks(10, 0);
      check_val("t6.no_count", 32'(bus_a.o_score_bcd), 32'h0000);
      check_val("t6.hi_clr", 32'(bus_a.o_hiscore_bcd), 32'h0000);
      pulse_start();
      run_ticks(TPP_A, 0);
      check_val("t6.recount", 32'(bus_a.o_score_bcd), 32'h0001);

      // random mix of starts, overs and ticks, including coincident events
      begin
         int since_tick;
         since_tick = 2;
         for (int c = 0; c < 15000; c++) begin
            game_start = ($urandom_range(0, 39) == 0);
            game_over  = ($urandom_range(0, 59) == 0);
            if (since_tick >= 2 && $urandom_range(0, 1) == 1) begin
               game_tick  = 1'b1;
               since_tick = 1;
            end else begin
               since_tick++;
            end
            step();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
